// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: runs 1..MAX_BYTES byte bursts through an spi byte engine under one registered slave select
module spi_burst_ctrl #(
  parameter int MAX_BYTES = 4,
  parameter int N_SLAVES = 2,
  parameter int SETUP_CLKS = 4,
  parameter int HOLD_CLKS = 4,
  localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1,
  localparam int NW = $clog2(MAX_BYTES + 1),
  localparam int DW = 8 * MAX_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [SW-1:0] slave_id,
  input  logic [NW-1:0] nbytes,
  input  logic [DW-1:0] tx_data,
  input  logic          mode_cpol,
  input  logic          mode_cpha,
  input  logic [15:0]   mode_dvsr,
  output logic          busy,
  output logic          done_tick,
  output logic [DW-1:0] rx_data,
  output logic [N_SLAVES-1:0] ss_n,
  output logic          spi_start,
  output logic [7:0]    spi_din,
  output logic          spi_cpol,
  output logic          spi_cpha,
  output logic [15:0]   spi_dvsr,
  input  logic          spi_ready,
  input  logic          spi_done_tick,
  input  logic [7:0]    spi_dout
);
  localparam int CMAX = SETUP_CLKS > HOLD_CLKS ? SETUP_CLKS : HOLD_CLKS;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [NW-1:0] bcnt;
  logic [DW-1:0] tx_sr, rx_sr;
  logic [NW+2:0] sh;
  logic ok, accept, setup_tc, hold_tc, rx_fire;
  assign busy = st != IDLE || done_tick;
  assign spi_din = tx_sr[DW-1 -: 8];
  // left-justify the request so the first byte always leaves from the top of tx_sr
  assign sh = {NW'(MAX_BYTES) - nbytes, 3'b000};
  always_comb begin
    ok = nbytes != '0 && nbytes <= NW'(MAX_BYTES) && {1'b0, slave_id} < (SW+1)'(N_SLAVES);
    accept = st == IDLE && !done_tick && start && ok;
    setup_tc = st == SETUP && cnt == CW'(SETUP_CLKS - 1);
    hold_tc = st == HOLD && cnt == CW'(HOLD_CLKS - 1);
    spi_start = st == ISSUE && spi_ready;
    rx_fire = st == WAIT && spi_done_tick;
    nxt = accept ? SETUP : setup_tc ? ISSUE : spi_start ? WAIT :
          rx_fire ? (bcnt == NW'(1) ? HOLD : ISSUE) : hold_tc ? IDLE : st;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      bcnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      ss_n <= '1;
      done_tick <= 1'b0;
      spi_cpol <= 1'b0;
      spi_cpha <= 1'b0;
      spi_dvsr <= '0;
    end else begin
      cnt <= (st == SETUP && !setup_tc) || (st == HOLD && !hold_tc) ? cnt + 1'b1 : '0;
      done_tick <= hold_tc;
      if (accept) begin
        ss_n <= ~(N_SLAVES'(1) << slave_id);
        spi_cpol <= mode_cpol;
        spi_cpha <= mode_cpha;
        spi_dvsr <= mode_dvsr;
        tx_sr <= tx_data << sh;
        rx_sr <= '0;
        bcnt <= nbytes;
      end
      if (spi_start) tx_sr <= tx_sr << 8;
      if (rx_fire) begin
        rx_sr <= (rx_sr << 8) | DW'(spi_dout);
        bcnt <= bcnt - 1'b1;
      end
      if (hold_tc) begin
        ss_n <= '1;
        rx_data <= rx_sr;
      end
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: directed bench for spi_burst_ctrl with a small byte-engine model attached
module tb_spi_burst_ctrl;
  localparam int ELAT = 2;
  localparam int SETUP = 4;
  localparam int HOLD = 4;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [0:0] slave_id = '0;
  logic [2:0] nbytes = '0;
  logic [31:0] tx_data = '0;
  logic mode_cpol = 1'b0, mode_cpha = 1'b0;
  logic [15:0] mode_dvsr = '0;
  logic busy, done_tick, spi_start, spi_cpol, spi_cpha;
  logic [31:0] rx_data;
  logic [1:0] ss_n;
  logic [7:0] spi_din;
  logic [15:0] spi_dvsr;
  logic spi_ready, spi_done_tick, pend;
  logic [7:0] spi_dout, ebyte;
  logic [3:0] ecnt;
  bit miso_one = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_burst_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .slave_id(slave_id), .nbytes(nbytes),
    .tx_data(tx_data), .mode_cpol(mode_cpol), .mode_cpha(mode_cpha), .mode_dvsr(mode_dvsr),
    .busy(busy), .done_tick(done_tick), .rx_data(rx_data), .ss_n(ss_n),
    .spi_start(spi_start), .spi_din(spi_din), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .spi_dvsr(spi_dvsr), .spi_ready(spi_ready), .spi_done_tick(spi_done_tick), .spi_dout(spi_dout)
  );

  // engine: ELAT cycles per byte, loopback or miso tied high; ready returns one cycle after done
  always @(posedge clk or negedge reset)
    if (!reset) begin
      spi_ready <= 1'b1;
      ecnt <= '0;
      spi_done_tick <= 1'b0;
      spi_dout <= '0;
      ebyte <= '0;
      pend <= 1'b0;
    end else begin
      spi_done_tick <= 1'b0;
      pend <= spi_done_tick;
      if (pend) spi_ready <= 1'b1;
      if (spi_start && spi_ready) begin
        spi_ready <= 1'b0;
        ecnt <= 4'(ELAT);
        ebyte <= spi_din;
      end else if (ecnt != 0) begin
        ecnt <= ecnt - 1'b1;
        if (ecnt == 1) begin
          spi_done_tick <= 1'b1;
          spi_dout <= miso_one ? 8'hFF : ebyte;
        end
      end
    end

  task automatic burst(input string nm, input logic sid, input logic [2:0] nb, input logic [31:0] data,
                       input logic pol, input logic pha, input logic [15:0] dv, input bit tied,
                       input int poke_at, input logic [31:0] exp_rx, input int exp_done);
    int done_at, first_st, last_dn, nst, bad;
    logic [31:0] sent;
    logic [63:0] m;
    logic [1:0] exp_ss;
    done_at = 0; first_st = 0; last_dn = 0; nst = 0; bad = 0; sent = '0;
    m = (64'd1 << (8 * nb)) - 64'd1;
    exp_ss = sid ? 2'b01 : 2'b10;
    miso_one = tied;
    slave_id = sid; nbytes = nb; tx_data = data;
    mode_cpol = pol; mode_cpha = pha; mode_dvsr = dv; start = 1'b1;
    for (int i = 1; i <= 300 && done_at == 0; i++) begin
      @(negedge clk);
      if (done_tick) begin
        done_at = i;
        if (ss_n !== 2'b11) bad++;
      end else if (ss_n !== exp_ss) bad++;
      if (busy !== 1'b1 || spi_cpol !== pol || spi_cpha !== pha || spi_dvsr !== dv) bad++;
      if (spi_start) begin
        nst++;
        sent = {sent[23:0], spi_din};
        if (first_st == 0) first_st = i;
      end
      if (spi_done_tick) last_dn = i;
      start = (i == poke_at) || (done_tick && poke_at < 0);
      if (start) begin
        slave_id = ~sid; nbytes = 3'd4; tx_data = 32'h11223344;
        mode_cpol = ~pol; mode_cpha = ~pha; mode_dvsr = 16'hBEEF;
      end
    end
    checks++;
    if (done_at == 0) begin errors++; $display("FAIL %s timeout: no done_tick within 300 cycles", nm); end
    checks++;
    if (done_at != exp_done) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, done_at, exp_done); end
    checks++;
    if (nst != int'(nb)) begin errors++; $display("FAIL %s spi_start count got %0d want %0d", nm, nst, nb); end
    checks++;
    if (sent !== (data & m[31:0])) begin errors++; $display("FAIL %s mosi bytes got %h want %h", nm, sent, data & m[31:0]); end
    checks++;
    if (first_st - 1 != SETUP) begin errors++; $display("FAIL %s setup margin got %0d want %0d", nm, first_st - 1, SETUP); end
    checks++;
    if (done_at - last_dn - 1 != HOLD) begin errors++; $display("FAIL %s hold margin got %0d want %0d", nm, done_at - last_dn - 1, HOLD); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s ss_n/busy/mode violations got %0d want 0", nm, bad); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rx_data !== exp_rx) begin errors++; $display("FAIL %s rx_data got %h want %h", nm, rx_data, exp_rx); end
    checks++;
    if (done_tick !== 1'b0 || busy !== 1'b0 || ss_n !== 2'b11)
      begin errors++; $display("FAIL %s post-burst done/busy/ss_n got %b%b%b want 0011", nm, done_tick, busy, ss_n); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (ss_n !== 2'b11) begin errors++; $display("FAIL reset ss_n got %b want 11", ss_n); end
    checks++;
    if (busy !== 1'b0 || done_tick !== 1'b0 || spi_start !== 1'b0)
      begin errors++; $display("FAIL reset busy/done/start got %b%b%b want 000", busy, done_tick, spi_start); end
    checks++;
    if (rx_data !== 32'h0) begin errors++; $display("FAIL reset rx_data got %h want 0", rx_data); end
    checks++;
    if (spi_cpol !== 1'b0 || spi_cpha !== 1'b0 || spi_dvsr !== 16'h0)
      begin errors++; $display("FAIL reset mode got %b%b %h want 00 0000", spi_cpol, spi_cpha, spi_dvsr); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    burst("single", 1'b0, 3'd1, 32'hFFFFFFA5, 1'b0, 1'b0, 16'd3, 1'b0, 0, 32'h000000A5, 13);
  endtask

  task automatic test_four;
    burst("four", 1'b1, 3'd4, 32'hDEADBEEF, 1'b0, 1'b1, 16'd3, 1'b0, 0, 32'hDEADBEEF, 28);
  endtask

  task automatic test_miso_high;
    burst("miso_high", 1'b0, 3'd2, 32'h00001234, 1'b1, 1'b0, 16'd4, 1'b1, 0, 32'h0000FFFF, 18);
  endtask

  task automatic test_reject;
    for (int k = 0; k < 2; k++) begin
      int nbad;
      nbad = 0;
      slave_id = 1'b0; nbytes = k ? 3'd5 : 3'd0; tx_data = 32'h01020304; start = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (ss_n !== 2'b11 || busy !== 1'b0 || done_tick !== 1'b0 || rx_data !== 32'h0000FFFF) nbad++;
      end
      checks++;
      if (nbad != 0) begin errors++; $display("FAIL reject_nb%0d violations got %0d want 0", nbytes, nbad); end
    end
    burst("poke_mid", 1'b0, 3'd1, 32'h000000C3, 1'b0, 1'b0, 16'd7, 1'b0, 3, 32'h000000C3, 13);
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    miso_one = 1'b0;
    slave_id = 1'b0; nbytes = 3'd3; tx_data = 32'h00A1B2C3;
    mode_cpol = 1'b1; mode_cpha = 1'b1; mode_dvsr = 16'd6; start = 1'b1;
    for (int i = 1; i <= 100 && seen == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (spi_done_tick) seen = i;
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL reset_mid timeout: no first byte done"); end
    @(negedge clk);
    checks++;
    if (ss_n !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL reset_mid pre ss_n/busy got %b%b want 101", ss_n, busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (ss_n !== 2'b11) begin errors++; $display("FAIL reset_mid ss_n got %b want 11", ss_n); end
    checks++;
    if (busy !== 1'b0 || spi_start !== 1'b0) begin errors++; $display("FAIL reset_mid busy/start got %b%b want 00", busy, spi_start); end
    checks++;
    if (rx_data !== 32'h0 || spi_dvsr !== 16'h0) begin errors++; $display("FAIL reset_mid rx/dvsr got %h %h want 0 0", rx_data, spi_dvsr); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    burst("post_reset", 1'b0, 3'd1, 32'h0000005A, 1'b1, 1'b1, 16'd9, 1'b0, 0, 32'h0000005A, 13);
  endtask

  task automatic test_back_to_back;
    burst("b2b_a", 1'b1, 3'd2, 32'h0000CAFE, 1'b0, 1'b1, 16'd2, 1'b0, -1, 32'h0000CAFE, 18);
    burst("b2b_b", 1'b0, 3'd3, 32'h00123456, 1'b1, 1'b0, 16'd5, 1'b0, 0, 32'h00123456, 23);
  endtask

  initial begin
    test_reset;
    test_single;
    test_four;
    test_miso_high;
    test_reject;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
